adder_sequencer: RTL

Initiator for the final-adder stage start/done handshake. It pulls operand pairs from an upstream valid/ready source and issues each pair to the add stage with a one-cycle start pulse. It feeds the stage's new values back as the next current values and, after N terms, presents the accumulated pair with a done pulse. It sits between the CORDIC output buffer and the final add stage, with a watchdog covering a stalled stage.

---
 rtl/adder_sequencer_pkg.sv | 15 +
 rtl/adder_sequencer_watchdog.sv | 38 +++
 rtl/adder_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/adder_sequencer_pkg.sv
// Shared constants and state encoding for the final-adder sequencer.
package adder_sequencer_pkg;

  localparam int                          FLOAT_DATA_WIDTH = 32;
  localparam logic [FLOAT_DATA_WIDTH-1:0] INIT_VAL         = 32'h0000_0000;  // +0.0

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } seq_state_e;

endpackage

// File: rtl/adder_sequencer_watchdog.sv
// Saturating delay counter with a synchronous clear. expired_o is high while
// the count sits at max_i; counting stops there until the next clear.
module seq_watchdog #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] max_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign expired_o = (count_q == max_i);

  // Next count: clear wins, otherwise step while enabled and not yet at max.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/adder_sequencer.sv
// Sequencer feeding operand pairs to the final add stage over a start/done
// handshake, chaining each stage result back in as the next current value.
module adder_sequencer #(
  parameter int                          FLOAT_DATA_WIDTH = adder_sequencer_pkg::FLOAT_DATA_WIDTH,
  parameter int                          COUNT_WIDTH      = 8,
  parameter int                          TIMEOUT_WIDTH    = 10,
  parameter logic [TIMEOUT_WIDTH-1:0]    TIMEOUT          = 10'd64,
  parameter logic [FLOAT_DATA_WIDTH-1:0] INIT_VAL         = adder_sequencer_pkg::INIT_VAL
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        start,
  input  logic [COUNT_WIDTH-1:0]      n_terms,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FLOAT_DATA_WIDTH-1:0] in_val_1,
  input  logic [FLOAT_DATA_WIDTH-1:0] in_val_2,
  output logic                        stage_start,
  output logic [FLOAT_DATA_WIDTH-1:0] stage_val_1,
  output logic [FLOAT_DATA_WIDTH-1:0] stage_val_2,
  output logic [FLOAT_DATA_WIDTH-1:0] stage_current_1,
  output logic [FLOAT_DATA_WIDTH-1:0] stage_current_2,
  input  logic [FLOAT_DATA_WIDTH-1:0] stage_new_1,
  input  logic [FLOAT_DATA_WIDTH-1:0] stage_new_2,
  input  logic                        stage_done,
  output logic [FLOAT_DATA_WIDTH-1:0] result_1,
  output logic [FLOAT_DATA_WIDTH-1:0] result_2,
  output logic                        done,
  output logic                        busy,
  output logic                        error
);

  import adder_sequencer_pkg::*;

  // Watchdog expires when its count reaches TIMEOUT-1; it counts from the
  // issue cycle, so a stall ends TIMEOUT cycles after the start pulse.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_MAX = TIMEOUT - TIMEOUT_WIDTH'(1);

  seq_state_e                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]      remaining_q, remaining_d;
  logic [FLOAT_DATA_WIDTH-1:0] acc_1_q, acc_1_d, acc_2_q, acc_2_d;
  logic [FLOAT_DATA_WIDTH-1:0] val_1_q, val_1_d, val_2_q, val_2_d;
  logic [FLOAT_DATA_WIDTH-1:0] res_1_q, res_1_d, res_2_q, res_2_d;
  logic [FLOAT_DATA_WIDTH-1:0] hold_1_q, hold_1_d, hold_2_q, hold_2_d;
  logic                        done_seen_q, done_seen_d;
  logic                        error_q, error_d;

  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  // The watchdog only runs across the issue/wait window of one term.
  assign wd_clear  = (state_q != ST_ISSUE) && (state_q != ST_WAIT);
  assign wd_enable = clk_en && !wd_clear;

  seq_watchdog #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (wd_clear),
    .enable_i  (wd_enable),
    .max_i     (WD_MAX),
    .expired_o (wd_expired)
  );

  assign stage_val_1     = val_1_q;
  assign stage_val_2     = val_2_q;
  assign stage_current_1 = acc_1_q;
  assign stage_current_2 = acc_2_q;
  assign busy            = (state_q != ST_IDLE);
  assign error           = error_q;
  // During the done pulse the accumulators are shown directly so a consumer
  // sampling on done sees the final values; the registered copy holds after.
  assign result_1 = (state_q == ST_FINISH) ? acc_1_q : res_1_q;
  assign result_2 = (state_q == ST_FINISH) ? acc_2_q : res_2_q;

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    acc_1_d     = acc_1_q;
    acc_2_d     = acc_2_q;
    val_1_d     = val_1_q;
    val_2_d     = val_2_q;
    res_1_d     = res_1_q;
    res_2_d     = res_2_q;
    hold_1_d    = hold_1_q;
    hold_2_d    = hold_2_q;
    done_seen_d = done_seen_q;
    error_d     = error_q;
    in_ready    = 1'b0;
    stage_start = 1'b0;
    done        = 1'b0;

    // A stage completion in WAIT is remembered even while frozen, together
    // with its results, which are only guaranteed valid during the pulse.
    if ((state_q == ST_WAIT) && stage_done) begin
      done_seen_d = 1'b1;
      hold_1_d    = stage_new_1;
      hold_2_d    = stage_new_2;
    end

    if (clk_en) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_1_d = INIT_VAL;
            acc_2_d = INIT_VAL;
            error_d = 1'b0;
            if (n_terms == '0) begin
              state_d = ST_FINISH;
            end else begin
              remaining_d = n_terms;
              state_d     = ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          in_ready = 1'b1;
          if (in_valid) begin
            val_1_d = in_val_1;
            val_2_d = in_val_2;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          stage_start = 1'b1;
          done_seen_d = 1'b0;
          state_d     = ST_WAIT;
        end
        ST_WAIT: begin
          if (stage_done || done_seen_q) begin
            acc_1_d     = stage_done ? stage_new_1 : hold_1_q;
            acc_2_d     = stage_done ? stage_new_2 : hold_2_q;
            done_seen_d = 1'b0;
            remaining_d = remaining_q - COUNT_WIDTH'(1);
            state_d     = (remaining_q == COUNT_WIDTH'(1)) ? ST_FINISH : ST_FETCH;
          end else if (wd_expired) begin
            error_d = 1'b1;
            state_d = ST_FINISH;
          end
        end
        ST_FINISH: begin
          done    = 1'b1;
          res_1_d = acc_1_q;
          res_2_d = acc_2_q;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      acc_1_q     <= INIT_VAL;
      acc_2_q     <= INIT_VAL;
      val_1_q     <= '0;
      val_2_q     <= '0;
      res_1_q     <= '0;
      res_2_q     <= '0;
      hold_1_q    <= '0;
      hold_2_q    <= '0;
      done_seen_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      acc_1_q     <= acc_1_d;
      acc_2_q     <= acc_2_d;
      val_1_q     <= val_1_d;
      val_2_q     <= val_2_d;
      res_1_q     <= res_1_d;
      res_2_q     <= res_2_d;
      hold_1_q    <= hold_1_d;
      hold_2_q    <= hold_2_d;
      done_seen_q <= done_seen_d;
      error_q     <= error_d;
    end
  end

endmodule
